// File: rtl/bloom_pkg.sv
// Shared types and constants for the bloom_filter requester front end.
//   op_e      : command opcode carried on cmd_op
//   state_e   : bloom_filter_initiator control FSM states
//   cnt_width : bit width needed to hold a small down-counter start value
package bloom_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_TAG_W  = 4;

    typedef enum logic {
        OP_QUERY  = 1'b0,
        OP_INSERT = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIns  = 3'd1,
        StQry  = 3'd2,
        StWait = 3'd3,
        StRsp  = 3'd4
    } state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear, has priority over inc
//   inc       : increment request (ignored once the count is all-ones)
//   count     : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/bloom_filter_initiator.sv
// Requester-side front end for the bloom_filter bit-array block.
// Accepts tagged insert/query commands, drives the filter insert/query pins, samples
// query_result after the filter's fixed latency and returns tagged hit/miss responses.
// Only one operation is outstanding at a time.
//   clk, rstn                     : clock, asynchronous active-low reset
//   cmd_valid/ready/op/data/tag   : command stream (op 0=query, 1=insert)
//   bf_insert_valid/data          : to filter insert port (registered, 1-cycle pulse)
//   bf_query_valid/data           : to filter query port (registered, 1-cycle pulse)
//   bf_query_result               : from filter, valid QUERY_LAT cycles after query_valid
//   rsp_valid/ready/hit/tag/data  : response stream (queries only, registered)
//   stats_clr                     : synchronous clear of the statistics counters
//   ins_cnt, qry_cnt, hit_cnt     : saturating statistics counters
module bloom_filter_initiator
    import bloom_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned TAG_W     = DEFAULT_TAG_W,
    parameter int unsigned QUERY_LAT = 1,
    parameter int unsigned INS_GAP   = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              bf_insert_valid,
    output logic [DATA_W-1:0] bf_insert_data,
    output logic              bf_query_valid,
    output logic [DATA_W-1:0] bf_query_data,
    input  logic              bf_query_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  ins_cnt,
    output logic [CNT_W-1:0]  qry_cnt,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam int unsigned LatW = cnt_width(QUERY_LAT);
    localparam int unsigned GapW = cnt_width(INS_GAP);

    state_e            state_q, state_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              bf_insert_valid_q, bf_insert_valid_d;
    logic [DATA_W-1:0] bf_insert_data_q, bf_insert_data_d;
    logic              bf_query_valid_q, bf_query_valid_d;
    logic [DATA_W-1:0] bf_query_data_q, bf_query_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic idle_ready;
    logic last_wait;
    logic ins_inc, qry_inc, hit_inc;

    assign idle_ready = (state_q == StIdle) && (gap_q == '0);
    // Final WAIT cycle: the filter result is valid exactly now.
    assign last_wait  = (state_q == StWait) && (lat_q == LatW'(1));

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        lat_d      = lat_q;
        key_d      = key_q;
        tag_d      = tag_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            StIdle: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GapW'(1);
                end
                if (cmd_valid && idle_ready) begin
                    key_d   = cmd_data;
                    tag_d   = cmd_tag;
                    state_d = (op_e'(cmd_op) == OP_INSERT) ? StIns : StQry;
                end
            end
            StIns: begin
                // Hold off the next command so the bit-array write is visible to it.
                gap_d   = GapW'(INS_GAP);
                state_d = StIdle;
            end
            StQry: begin
                lat_d   = LatW'(QUERY_LAT);
                state_d = StWait;
            end
            StWait: begin
                lat_d = lat_q - LatW'(1);
                if (last_wait) begin
                    rsp_hit_d  = bf_query_result;
                    rsp_tag_d  = tag_q;
                    rsp_data_d = key_q;
                    state_d    = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        bf_insert_valid_d = (state_d == StIns);
        bf_query_valid_d  = (state_d == StQry);
        rsp_valid_d       = (state_d == StRsp);
        bf_insert_data_d  = (state_d == StIns) ? key_d : bf_insert_data_q;
        bf_query_data_d   = (state_d == StQry) ? key_d : bf_query_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= StIdle;
            gap_q             <= '0;
            lat_q             <= '0;
            key_q             <= '0;
            tag_q             <= '0;
            bf_insert_valid_q <= 1'b0;
            bf_insert_data_q  <= '0;
            bf_query_valid_q  <= 1'b0;
            bf_query_data_q   <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_hit_q         <= 1'b0;
            rsp_tag_q         <= '0;
            rsp_data_q        <= '0;
        end else begin
            state_q           <= state_d;
            gap_q             <= gap_d;
            lat_q             <= lat_d;
            key_q             <= key_d;
            tag_q             <= tag_d;
            bf_insert_valid_q <= bf_insert_valid_d;
            bf_insert_data_q  <= bf_insert_data_d;
            bf_query_valid_q  <= bf_query_valid_d;
            bf_query_data_q   <= bf_query_data_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_hit_q         <= rsp_hit_d;
            rsp_tag_q         <= rsp_tag_d;
            rsp_data_q        <= rsp_data_d;
        end
    end

    assign cmd_ready       = idle_ready;
    assign bf_insert_valid = bf_insert_valid_q;
    assign bf_insert_data  = bf_insert_data_q;
    assign bf_query_valid  = bf_query_valid_q;
    assign bf_query_data   = bf_query_data_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_hit         = rsp_hit_q;
    assign rsp_tag         = rsp_tag_q;
    assign rsp_data        = rsp_data_q;

    assign ins_inc = (state_q == StIns);
    assign qry_inc = (state_q == StQry);
    assign hit_inc = last_wait && bf_query_result;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ins_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (stats_clr),
        .inc   (ins_inc),
        .count (ins_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_qry_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (stats_clr),
        .inc   (qry_inc),
        .count (qry_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (stats_clr),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

endmodule

// File: tb/tb_bloom_filter_initiator.sv
// Directed bench for bloom_filter_initiator.
// Instance 0: QUERY_LAT=1, INS_GAP=1, CNT_W=16.  Instance 1: QUERY_LAT=3, INS_GAP=3, CNT_W=4.
// Each instance talks to its own exact-set filter model.
module tb_bloom_filter_initiator;

    logic        clk;
    logic        rstn;
    logic [1:0]  cmd_valid, cmd_op, rsp_ready, stats_clr;
    logic [31:0] cmd_data [2];
    logic [3:0]  cmd_tag [2];
    logic [1:0]  cmd_ready, bf_insert_valid, bf_query_valid, bf_query_result;
    logic [1:0]  rsp_valid, rsp_hit;
    logic [31:0] bf_insert_data [2];
    logic [31:0] bf_query_data [2];
    logic [31:0] rsp_data [2];
    logic [3:0]  rsp_tag [2];
    logic [15:0] ins_cnt_a, qry_cnt_a, hit_cnt_a;
    logic [3:0]  ins_cnt_b, qry_cnt_b, hit_cnt_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bloom_filter_initiator #(
        .DATA_W(32), .TAG_W(4), .QUERY_LAT(1), .INS_GAP(1), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_data(cmd_data[0]), .cmd_tag(cmd_tag[0]),
        .bf_insert_valid(bf_insert_valid[0]), .bf_insert_data(bf_insert_data[0]),
        .bf_query_valid(bf_query_valid[0]), .bf_query_data(bf_query_data[0]),
        .bf_query_result(bf_query_result[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_hit(rsp_hit[0]),
        .rsp_tag(rsp_tag[0]), .rsp_data(rsp_data[0]),
        .stats_clr(stats_clr[0]), .ins_cnt(ins_cnt_a), .qry_cnt(qry_cnt_a), .hit_cnt(hit_cnt_a)
    );

    bloom_filter_initiator #(
        .DATA_W(32), .TAG_W(4), .QUERY_LAT(3), .INS_GAP(3), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_data(cmd_data[1]), .cmd_tag(cmd_tag[1]),
        .bf_insert_valid(bf_insert_valid[1]), .bf_insert_data(bf_insert_data[1]),
        .bf_query_valid(bf_query_valid[1]), .bf_query_data(bf_query_data[1]),
        .bf_query_result(bf_query_result[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_hit(rsp_hit[1]),
        .rsp_tag(rsp_tag[1]), .rsp_data(rsp_data[1]),
        .stats_clr(stats_clr[1]), .ins_cnt(ins_cnt_b), .qry_cnt(qry_cnt_b), .hit_cnt(hit_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Filter models: exact key sets; result valid only QUERY_LAT cycles after query_valid.
    logic [31:0] keys0 [$];
    logic [31:0] keys1 [$];
    logic a_v, a_h, b_v1, b_h1, b_v2, b_h2, b_v3, b_h3;

    function automatic logic lookup(input int k, input logic [31:0] key);
        if (k == 0) begin
            foreach (keys0[i]) if (keys0[i] == key) return 1'b1;
        end else begin
            foreach (keys1[i]) if (keys1[i] == key) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (bf_insert_valid[0]) keys0.push_back(bf_insert_data[0]);
        if (bf_insert_valid[1]) keys1.push_back(bf_insert_data[1]);
        a_v  <= bf_query_valid[0];
        a_h  <= lookup(0, bf_query_data[0]);
        b_v1 <= bf_query_valid[1];
        b_h1 <= lookup(1, bf_query_data[1]);
        b_v2 <= b_v1;
        b_h2 <= b_h1;
        b_v3 <= b_v2;
        b_h3 <= b_h2;
    end

    assign bf_query_result[0] = a_v  ? a_h  : 1'bx;
    assign bf_query_result[1] = b_v3 ? b_h3 : 1'bx;

    // Pulse monitor.
    int iv_cnt [2] = '{0, 0};
    int qv_cnt [2] = '{0, 0};
    int qv_cyc [2] = '{0, 0};
    int iv_cyc [2] = '{0, 0};
    logic [1:0] overlap = 2'b00;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bf_insert_valid[k]) begin
                iv_cnt[k] <= iv_cnt[k] + 1;
                iv_cyc[k] <= cyc;
            end
            if (bf_query_valid[k]) begin
                qv_cnt[k] <= qv_cnt[k] + 1;
                qv_cyc[k] <= cyc;
            end
            if (bf_insert_valid[k] && bf_query_valid[k]) overlap[k] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends at a negedge; acc is the cycle in which the handshake happened.
    task automatic do_cmd(input int k, input logic op, input logic [31:0] key,
                          input logic [3:0] tag, output int acc);
        int n;
        cmd_valid[k] = 1'b1;
        cmd_op[k]    = op;
        cmd_data[k]  = key;
        cmd_tag[k]   = tag;
        n = 0;
        while (!cmd_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_accept", {31'd0, cmd_ready[k]}, 32'd1);
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int rc);
        int n;
        n = 0;
        while (!rsp_valid[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_seen", {31'd0, rsp_valid[k]}, 32'd1);
        rc = cyc;
    endtask

    task automatic finish_rsp(input int k);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check_eq("rsp_drop", {31'd0, rsp_valid[k]}, 32'd0);
        check_eq("ready_after_rsp", {31'd0, cmd_ready[k]}, 32'd1);
    endtask

    initial begin
        int t_i, t_q, rc, h, pulses, bad_rsp, bad_rdy;

        rstn      = 1'b0;
        cmd_valid = '0;
        cmd_op    = '0;
        rsp_ready = '0;
        stats_clr = '0;
        cmd_data  = '{32'd0, 32'd0};
        cmd_tag   = '{4'd0, 4'd0};
        repeat (2) @(negedge clk);

        check_eq("rst_a_flags", {27'd0, cmd_ready[0], bf_insert_valid[0], bf_query_valid[0],
                 rsp_valid[0], rsp_hit[0]}, 32'h10);
        check_eq("rst_a_data", rsp_data[0] | bf_query_data[0] | bf_insert_data[0], 32'd0);
        check_eq("rst_a_cnt", {ins_cnt_a, qry_cnt_a | hit_cnt_a}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Insert then query the same key: hit, 3-cycle response latency.
        do_cmd(0, 1'b1, 32'hc0a9011e, 4'd0, t_i);
        do_cmd(0, 1'b0, 32'hc0a9011e, 4'd3, t_q);
        wait_rsp(0, rc);
        check_eq("q1_latency", rc - t_q, 32'd3);
        check_eq("q1_hit", {31'd0, rsp_hit[0]}, 32'd1);
        check_eq("q1_tag", {28'd0, rsp_tag[0]}, 32'd3);
        check_eq("q1_data", rsp_data[0], 32'hc0a9011e);
        check_eq("q1_qv_cycle", qv_cyc[0] - t_q, 32'd1);
        check_eq("i1_iv_cycle", iv_cyc[0] - t_i, 32'd1);
        check_eq("q1_pulses", {qv_cnt[0][15:0], iv_cnt[0][15:0]}, 32'h0001_0001);
        finish_rsp(0);

        // Miss on a never-inserted key, then insert/query another key.
        do_cmd(0, 1'b0, 32'hc0a90128, 4'd4, t_q);
        wait_rsp(0, rc);
        check_eq("q2_miss", {31'd0, rsp_hit[0]}, 32'd0);
        check_eq("q2_tag", {28'd0, rsp_tag[0]}, 32'd4);
        finish_rsp(0);
        do_cmd(0, 1'b1, 32'hc0a8011e, 4'd0, t_i);
        do_cmd(0, 1'b0, 32'hc0a8011e, 4'd7, t_q);
        wait_rsp(0, rc);
        check_eq("q3_hit", {31'd0, rsp_hit[0]}, 32'd1);
        check_eq("q3_data", rsp_data[0], 32'hc0a8011e);
        finish_rsp(0);
        check_eq("cnt_ins_a", {16'd0, ins_cnt_a}, 32'd2);
        check_eq("cnt_qry_a", {16'd0, qry_cnt_a}, 32'd3);
        check_eq("cnt_hit_a", {16'd0, hit_cnt_a}, 32'd2);

        // Backpressure: response held 5 cycles with a command pending.
        do_cmd(0, 1'b0, 32'hc0a9011e, 4'd5, t_q);
        wait_rsp(0, rc);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 1'b0;
        cmd_data[0]  = 32'hc0a90200;
        cmd_tag[0]   = 4'd6;
        pulses  = iv_cnt[0] + qv_cnt[0];
        bad_rsp = 0;
        bad_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(rsp_valid[0] === 1'b1 && rsp_hit[0] === 1'b1 && rsp_tag[0] === 4'd5 &&
                  rsp_data[0] === 32'hc0a9011e)) bad_rsp++;
            if (cmd_ready[0] !== 1'b0) bad_rdy++;
        end
        check_eq("hold_rsp_stable", bad_rsp, 32'd0);
        check_eq("hold_cmd_ready_low", bad_rdy, 32'd0);
        check_eq("hold_no_pulses", iv_cnt[0] + qv_cnt[0], pulses);
        rsp_ready[0] = 1'b1;
        h = cyc;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check_eq("post_hs_ready", {31'd0, cmd_ready[0]}, 32'd1);
        check_eq("post_hs_rsp_low", {31'd0, rsp_valid[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check_eq("pend_qv", {31'd0, bf_query_valid[0]}, 32'd1);
        check_eq("pend_qv_cycle", cyc - h, 32'd2);
        check_eq("pend_qdata", bf_query_data[0], 32'hc0a90200);
        wait_rsp(0, rc);
        check_eq("pend_miss_tag", {27'd0, rsp_hit[0], rsp_tag[0]}, 32'h06);
        finish_rsp(0);

        // Insert immediately followed by a query, INS_GAP=1.
        do_cmd(0, 1'b1, 32'hc0a90300, 4'd0, t_i);
        do_cmd(0, 1'b0, 32'hc0a90300, 4'd1, t_q);
        check_eq("gap1_accept", t_q - t_i, 32'd3);
        wait_rsp(0, rc);
        check_eq("gap1_qv_cycle", qv_cyc[0] - t_i, 32'd4);
        check_eq("gap1_hit", {31'd0, rsp_hit[0]}, 32'd1);
        finish_rsp(0);

        // Instance 1: INS_GAP=3, QUERY_LAT=3.
        do_cmd(1, 1'b1, 32'hc0a90001, 4'd0, t_i);
        do_cmd(1, 1'b0, 32'hc0a90001, 4'd9, t_q);
        check_eq("gap3_accept", t_q - t_i, 32'd5);
        wait_rsp(1, rc);
        check_eq("lat3_latency", rc - t_q, 32'd5);
        check_eq("lat3_qv_cycle", qv_cyc[1] - t_q, 32'd1);
        check_eq("lat3_hit", {31'd0, rsp_hit[1]}, 32'd1);
        check_eq("lat3_tag", {28'd0, rsp_tag[1]}, 32'd9);
        finish_rsp(1);
        do_cmd(1, 1'b0, 32'hc0a90099, 4'd2, t_q);
        wait_rsp(1, rc);
        check_eq("lat3_miss", {31'd0, rsp_hit[1]}, 32'd0);
        finish_rsp(1);

        // Reset during WAIT discards the query.
        do_cmd(1, 1'b0, 32'hc0a90001, 4'd3, t_q);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("rst_b_flags", {27'd0, cmd_ready[1], bf_insert_valid[1], bf_query_valid[1],
                 rsp_valid[1], rsp_hit[1]}, 32'h10);
        check_eq("rst_b_data", rsp_data[1] | bf_query_data[1] | {28'd0, rsp_tag[1]}, 32'd0);
        check_eq("rst_b_cnt", {20'd0, ins_cnt_b, qry_cnt_b, hit_cnt_b}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) bad_rsp++;
        end
        check_eq("rst_no_stale_rsp", bad_rsp, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready[1]}, 32'd1);

        // 17 queries saturate the 4-bit counters.
        for (int i = 0; i < 17; i++) begin
            do_cmd(1, 1'b0, 32'hc0a90001, 4'(i), t_q);
            wait_rsp(1, rc);
            finish_rsp(1);
        end
        check_eq("sat_qry_b", {28'd0, qry_cnt_b}, 32'd15);
        check_eq("sat_hit_b", {28'd0, hit_cnt_b}, 32'd15);
        check_eq("sat_ins_b", {28'd0, ins_cnt_b}, 32'd0);

        // stats_clr in the same cycle as the query increment: clear wins.
        do_cmd(1, 1'b0, 32'hc0a90001, 4'd4, t_q);
        stats_clr[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stats_clr[1] = 1'b0;
        check_eq("clr_qry_b", {28'd0, qry_cnt_b}, 32'd0);
        check_eq("clr_hit_b", {28'd0, hit_cnt_b}, 32'd0);
        wait_rsp(1, rc);
        finish_rsp(1);
        check_eq("clr_hit_after", {28'd0, hit_cnt_b}, 32'd1);
        check_eq("clr_qry_after", {28'd0, qry_cnt_b}, 32'd0);

        check_eq("no_overlap", {30'd0, overlap}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
